// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
package md_unit_pkg;

    // md_op encodings driven by EX
    localparam logic [2:0] MdMult  = 3'd0;
    localparam logic [2:0] MdMultu = 3'd1;
    localparam logic [2:0] MdDiv   = 3'd2;
    localparam logic [2:0] MdDivu  = 3'd3;
    localparam logic [2:0] MdMthi  = 3'd4;
    localparam logic [2:0] MdMtlo  = 3'd5;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } md_state_e;

endpackage

// File: rtl/md_if.sv
// EX-side bundle for the multiply/divide unit: request strobe, operands, busy and HI/LO readback.
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // EX stage drives requests and reads HI/LO
    modport master (
        output start, md_op, a, b,
        input  busy, hi, lo
    );

    // md_unit consumes requests and owns HI/LO
    modport slave (
        input  start, md_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO. Results are computed at the
// start edge into shadow registers and committed when the latency countdown expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic clk,
    input logic rst,
    md_if.slave md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     sh_hi_q, sh_hi_d;
    logic [31:0]     sh_lo_q, sh_lo_d;
    logic            commit_q, commit_d;  // low for divide-by-zero: leave HI/LO untouched
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               b_nz;
    logic [31:0]        div_b;
    logic               div_ovf;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;

    // Result datapath: signed/unsigned product and quotient/remainder of the live operands
    always_comb begin
        prod_s  = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
        prod_u  = {32'd0, md.a} * {32'd0, md.b};
        b_nz    = (md.b != 32'd0);
        // Substitute a harmless divisor on zero; the result is discarded anyway
        div_b   = b_nz ? md.b : 32'd1;
        div_ovf = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);
        if (div_ovf) begin
            quo_s = 32'sh8000_0000;
            rem_s = 32'sd0;
        end else begin
            quo_s = $signed(md.a) / $signed(div_b);
            rem_s = $signed(md.a) % $signed(div_b);
        end
        quo_u = md.a / div_b;
        rem_u = md.a % div_b;
    end

    // Next-state: accept requests while idle, count down while running, commit on 1->0
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_hi_d  = sh_hi_q;
        sh_lo_d  = sh_lo_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (md.start) begin
                    case (md.md_op)
                        MdMult: begin
                            sh_hi_d  = prod_s[63:32];
                            sh_lo_d  = prod_s[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CntW'(MULT_CYCLES);
                            state_d  = StRun;
                        end
                        MdMultu: begin
                            sh_hi_d  = prod_u[63:32];
                            sh_lo_d  = prod_u[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CntW'(MULT_CYCLES);
                            state_d  = StRun;
                        end
                        MdDiv: begin
                            sh_hi_d  = rem_s;
                            sh_lo_d  = quo_s;
                            commit_d = b_nz;
                            cnt_d    = CntW'(DIV_CYCLES);
                            state_d  = StRun;
                        end
                        MdDivu: begin
                            sh_hi_d  = rem_u;
                            sh_lo_d  = quo_u;
                            commit_d = b_nz;
                            cnt_d    = CntW'(DIV_CYCLES);
                            state_d  = StRun;
                        end
                        MdMthi:  hi_d = md.a;
                        MdMtlo:  lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (commit_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset that also discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sh_hi_q  <= '0;
            sh_lo_q  <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_hi_q  <= sh_hi_d;
            sh_lo_q  <= sh_lo_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md.busy = (state_q == StRun);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO pushed to a scoreboard at start, popped at commit.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk;
    logic rst;
    md_if bus ();

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .md (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one multi-cycle op, count busy cycles, then compare the committed HI/LO
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit interfere);
        int          cnt;
        logic [63:0] exp;
        sb_q.push_back({ehi, elo});
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = b + 32'd1;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 64) begin
            cnt++;
            if (cnt == 1) begin
                check({tag, " hold hi"}, {32'd0, bus.hi}, {32'd0, mhi});
                check({tag, " hold lo"}, {32'd0, bus.lo}, {32'd0, mlo});
            end
            if (interfere && cnt == 2) begin
                bus.start = 1'b1;
                bus.md_op = op;
                bus.a     = 32'h7;
                bus.b     = 32'h9;
            end
            step();
            bus.start = 1'b0;
        end
        check({tag, " busy cycles"}, 64'(cnt), 64'(n));
        exp = sb_q.pop_front();
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp[63:32]});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp[31:0]});
        mhi = exp[63:32];
        mlo = exp[31:0];
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.md_op = MdMult;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'hCAFE_F00D;
        repeat (3) step();
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset hi", {32'd0, bus.hi}, 64'd0);
        check("reset lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;
        step();

        run_op("mult", MdMult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run_op("div", MdDiv, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", MdDivu, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
        run_op("div ovf", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

        // Zero-latency moves land on the very next edge with no busy
        bus.start = 1'b1;
        bus.md_op = MdMthi;
        bus.a     = 32'h1234;
        step();
        check("mthi hi", {32'd0, bus.hi}, 64'h1234);
        check("mthi busy", {63'd0, bus.busy}, 64'd0);
        bus.md_op = MdMtlo;
        bus.a     = 32'h5678;
        step();
        bus.start = 1'b0;
        check("mtlo lo", {32'd0, bus.lo}, 64'h5678);
        check("mtlo hi kept", {32'd0, bus.hi}, 64'h1234);
        check("mtlo busy", {63'd0, bus.busy}, 64'd0);
        mhi = 32'h1234;
        mlo = 32'h5678;

        run_op("div0", MdDiv, 32'd99, 32'd0, 10, mhi, mlo, 1'b0);
        run_op("divu0", MdDivu, 32'd99, 32'd0, 10, mhi, mlo, 1'b0);

        // Unknown opcode does nothing
        bus.start = 1'b1;
        bus.md_op = 3'd7;
        bus.a     = 32'hAAAA_5555;
        bus.b     = 32'd3;
        step();
        bus.start = 1'b0;
        check("unk busy", {63'd0, bus.busy}, 64'd0);
        check("unk hi", {32'd0, bus.hi}, {32'd0, mhi});
        check("unk lo", {32'd0, bus.lo}, {32'd0, mlo});

        // Second start during busy must be ignored
        run_op("mult ign", MdMult, 32'h0001_0000, 32'h0003_0000, 5, 32'd3, 32'd0, 1'b1);

        // Reset mid-divide discards the operation
        bus.start = 1'b1;
        bus.md_op = MdDiv;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("rst pre busy", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        check("rst hi", {32'd0, bus.hi}, 64'd0);
        check("rst lo", {32'd0, bus.lo}, 64'd0);
        repeat (12) step();
        check("rst late busy", {63'd0, bus.busy}, 64'd0);
        check("rst late hi", {32'd0, bus.hi}, 64'd0);
        check("rst late lo", {32'd0, bus.lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
